// File: rtl/hazard_ctrl.sv
// hazard_ctrl: consumer end of the pipeline hazard encoding.
//
// Combines per-stage Tuse flags, register addresses and result-class codes
// into a D-stage stall and operand forwarding selects. It also owns the
// multiply/divide busy counter, which stalls HI/LO-class instructions in D
// while the MD unit is busy.
//
// Build option: define HAZ_FWD_EN to enable forwarding. Without it, every
// fwd_* output is 0 and D stalls on any E/M producer match of a source it
// reads.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   tuse_rs0/1, tuse_rt0/1/2  D instruction Tuse flags for rs/rt
//   a1_d, a2_d              D rs/rt
//   a1_e, a2_e, a3_e        E rs/rt/dest
//   a2_m, a3_m              M rt/dest
//   a3_w                    W dest
//   res_e, res_m, res_w     result class: 00 none, 01 alu, 10 dm, 11 pc
//   md_use_d                D instruction uses the MD unit
//   md_start_e, md_div_e    E starts mult (md_div_e=0) or div (md_div_e=1)
//   stall                   freeze F/D, bubble E
//   fwd_rs_d, fwd_rt_d      0 GRF, 1 E.pc8, 2 M.alu, 3 M.pc8, 4 W.wd
//   fwd_rs_e, fwd_rt_e      0 pipe reg, 1 M.alu, 2 M.pc8, 3 W.wd
//   fwd_rt_m                0 pipe reg, 1 W.wd
//   md_busy                 MD unit busy
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tuse_rs0,
  input  logic       tuse_rs1,
  input  logic       tuse_rt0,
  input  logic       tuse_rt1,
  input  logic       tuse_rt2,
  input  logic [4:0] a1_d,
  input  logic [4:0] a2_d,
  input  logic [4:0] a1_e,
  input  logic [4:0] a2_e,
  input  logic [4:0] a3_e,
  input  logic [4:0] a2_m,
  input  logic [4:0] a3_m,
  input  logic [4:0] a3_w,
  input  logic [1:0] res_e,
  input  logic [1:0] res_m,
  input  logic [1:0] res_w,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_div_e,
  output logic       stall,
  output logic [2:0] fwd_rs_d,
  output logic [2:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b01;
  localparam logic [1:0] RES_DM   = 2'b10;
  localparam logic [1:0] RES_PC   = 2'b11;

  localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CW_RAW = $clog2(MD_MAX + 1);
  localparam int unsigned CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic produces(input logic [1:0] res, input logic [4:0] a3,
                                    input logic [4:0] r);
    return (res != RES_NONE) && (a3 == r) && (r != 5'd0);
  endfunction

  // E/M producers of the D sources
  logic e_rs, e_rt, m_rs, m_rt;
  assign e_rs = produces(res_e, a3_e, a1_d);
  assign e_rt = produces(res_e, a3_e, a2_d);
  assign m_rs = produces(res_m, a3_m, a1_d);
  assign m_rt = produces(res_m, a3_m, a2_d);

  logic data_stall;

`ifdef HAZ_FWD_EN
  function automatic logic [1:0] tnew_e(input logic [1:0] res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input logic [1:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // Any set Tuse flag earlier than the producer's Tnew means the value
  // cannot be forwarded in time.
  function automatic logic too_late(input logic t0, input logic t1, input logic t2,
                                    input logic [1:0] n);
    return (t0 && (n > 2'd0)) || (t1 && (n > 2'd1)) || (t2 && (n > 2'd2));
  endfunction

  logic w_rs, w_rt, m_e1, m_e2, w_e1, w_e2, w_m2;
  assign w_rs = produces(res_w, a3_w, a1_d);
  assign w_rt = produces(res_w, a3_w, a2_d);
  assign m_e1 = produces(res_m, a3_m, a1_e);
  assign m_e2 = produces(res_m, a3_m, a2_e);
  assign w_e1 = produces(res_w, a3_w, a1_e);
  assign w_e2 = produces(res_w, a3_w, a2_e);
  assign w_m2 = produces(res_w, a3_w, a2_m);

  assign data_stall =
      (e_rs && too_late(tuse_rs0, tuse_rs1, 1'b0, tnew_e(res_e))) ||
      (m_rs && too_late(tuse_rs0, tuse_rs1, 1'b0, tnew_m(res_m))) ||
      (e_rt && too_late(tuse_rt0, tuse_rt1, tuse_rt2, tnew_e(res_e))) ||
      (m_rt && too_late(tuse_rt0, tuse_rt1, tuse_rt2, tnew_m(res_m)));

  // Nearest producer wins; if it is not ready yet the select stays 0 and
  // the stall keeps the stale value from being consumed.
  always_comb begin
    fwd_rs_d = '0;
    fwd_rt_d = '0;
    fwd_rs_e = '0;
    fwd_rt_e = '0;
    fwd_rt_m = 1'b0;

    if (e_rs) begin
      if (tnew_e(res_e) == 2'd0) fwd_rs_d = 3'd1;
    end else if (m_rs) begin
      if (tnew_m(res_m) == 2'd0) fwd_rs_d = (res_m == RES_PC) ? 3'd3 : 3'd2;
    end else if (w_rs) begin
      fwd_rs_d = 3'd4;
    end

    if (e_rt) begin
      if (tnew_e(res_e) == 2'd0) fwd_rt_d = 3'd1;
    end else if (m_rt) begin
      if (tnew_m(res_m) == 2'd0) fwd_rt_d = (res_m == RES_PC) ? 3'd3 : 3'd2;
    end else if (w_rt) begin
      fwd_rt_d = 3'd4;
    end

    if (m_e1) begin
      if (tnew_m(res_m) == 2'd0) fwd_rs_e = (res_m == RES_PC) ? 2'd2 : 2'd1;
    end else if (w_e1) begin
      fwd_rs_e = 2'd3;
    end

    if (m_e2) begin
      if (tnew_m(res_m) == 2'd0) fwd_rt_e = (res_m == RES_PC) ? 2'd2 : 2'd1;
    end else if (w_e2) begin
      fwd_rt_e = 2'd3;
    end

    if (w_m2) fwd_rt_m = 1'b1;
  end
`else
  assign data_stall = ((tuse_rs0 || tuse_rs1) && (e_rs || m_rs)) ||
                      ((tuse_rt0 || tuse_rt1 || tuse_rt2) && (e_rt || m_rt));

  assign fwd_rs_d = '0;
  assign fwd_rt_d = '0;
  assign fwd_rs_e = '0;
  assign fwd_rt_e = '0;
  assign fwd_rt_m = 1'b0;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{a1_e, a2_e, a2_m, a3_w, res_w};
`endif

  // MD busy counter: a start reloads (never accumulates), otherwise count down.
  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_e) begin
      md_cnt <= md_div_e ? DIV_LD : MULT_LD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_ONE;
    end
  end

  assign md_busy = md_start_e || (md_cnt != '0);
  assign stall   = data_stall || (md_use_d && md_busy);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// MD-counter sequences, and randomized stimulus against a behavioural model.
// Works for both builds (HAZ_FWD_EN defined or not).
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk;
  logic       reset;
  logic       tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
  logic [4:0] a1_d, a2_d, a1_e, a2_e, a3_e, a2_m, a3_m, a3_w;
  logic [1:0] res_e, res_m, res_w;
  logic       md_use_d, md_start_e, md_div_e;
  logic       stall;
  logic [2:0] fwd_rs_d, fwd_rt_d;
  logic [1:0] fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;
  logic       md_busy;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .tuse_rs0(tuse_rs0), .tuse_rs1(tuse_rs1),
    .tuse_rt0(tuse_rt0), .tuse_rt1(tuse_rt1), .tuse_rt2(tuse_rt2),
    .a1_d(a1_d), .a2_d(a2_d), .a1_e(a1_e), .a2_e(a2_e), .a3_e(a3_e),
    .a2_m(a2_m), .a3_m(a3_m), .a3_w(a3_w),
    .res_e(res_e), .res_m(res_m), .res_w(res_w),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_end = -1;   // last cycle index at which MD is busy from an earlier start

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Tnew per result class (index = res code); class none never produces.
  int tn_e[4] = '{0, 1, 2, 0};
  int tn_m[4] = '{0, 0, 1, 0};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2} = '0;
    {a1_d, a2_d, a1_e, a2_e, a3_e, a2_m, a3_m, a3_w} = '0;
    {res_e, res_m, res_w} = '0;
    {md_use_d, md_start_e, md_div_e} = '0;
  endtask

  // Model time advance: the MD unit is busy through start_cycle + N.
  task automatic advance();
    if (reset) busy_end = cyc;
    else if (md_start_e) busy_end = cyc + (md_div_e ? DIV_N : MULT_N);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit produces(input logic [1:0] res, input logic [4:0] a3,
                                  input logic [4:0] r);
    return (res != 2'b00) && (a3 == r) && (r != 5'd0);
  endfunction

  function automatic int exp_busy();
    return (md_start_e || (cyc <= busy_end)) ? 1 : 0;
  endfunction

  function automatic int exp_stall();
    logic [4:0] src [2];
    bit fl [2][3];
    bit st;
    st = 1'b0;
    src[0] = a1_d; src[1] = a2_d;
    fl[0][0] = tuse_rs0; fl[0][1] = tuse_rs1; fl[0][2] = 1'b0;
    fl[1][0] = tuse_rt0; fl[1][1] = tuse_rt1; fl[1][2] = tuse_rt2;
    for (int p = 0; p < 2; p++) begin
      logic [1:0] res;
      logic [4:0] a3;
      int n;
      res = (p == 0) ? res_e : res_m;
      a3  = (p == 0) ? a3_e : a3_m;
      n   = (p == 0) ? tn_e[res] : tn_m[res];
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 3; t++)
          if (fl[s][t] && produces(res, a3, src[s]))
            if (!FWD || n > t) st = 1'b1;
    end
    if (md_use_d && exp_busy() == 1) st = 1'b1;
    return st ? 1 : 0;
  endfunction

  // -1 marks a don't-care select (nearest producer not ready yet).
  function automatic int exp_fwd_d(input logic [4:0] r);
    if (!FWD) return 0;
    if (produces(res_e, a3_e, r)) return (tn_e[res_e] == 0) ? 1 : -1;
    if (produces(res_m, a3_m, r)) return (tn_m[res_m] == 0) ? ((res_m == 2'b01) ? 2 : 3) : -1;
    if (produces(res_w, a3_w, r)) return 4;
    return 0;
  endfunction

  function automatic int exp_fwd_e(input logic [4:0] r);
    if (!FWD) return 0;
    if (produces(res_m, a3_m, r)) return (tn_m[res_m] == 0) ? ((res_m == 2'b01) ? 1 : 2) : -1;
    if (produces(res_w, a3_w, r)) return 3;
    return 0;
  endfunction

  task automatic model_check();
    int e;
    chk("m_stall", int'(stall), exp_stall());
    chk("m_md_busy", int'(md_busy), exp_busy());
    e = exp_fwd_d(a1_d); if (e >= 0) chk("m_fwd_rs_d", int'(fwd_rs_d), e);
    e = exp_fwd_d(a2_d); if (e >= 0) chk("m_fwd_rt_d", int'(fwd_rt_d), e);
    e = exp_fwd_e(a1_e); if (e >= 0) chk("m_fwd_rs_e", int'(fwd_rs_e), e);
    e = exp_fwd_e(a2_e); if (e >= 0) chk("m_fwd_rt_e", int'(fwd_rt_e), e);
    chk("m_fwd_rt_m", int'(fwd_rt_m), (FWD && produces(res_w, a3_w, a2_m)) ? 1 : 0);
  endtask

  typedef struct {
    logic       t_rs0, t_rs1, t_rt0, t_rt1, t_rt2;
    logic [4:0] a1_d, a2_d, a1_e, a3_e, a2_m, a3_m, a3_w;
    logic [1:0] res_e, res_m, res_w;
    int         stall_f;   // expected stall, forwarding build
    int         stall_n;   // expected stall, no-forwarding build
    int         rs_d;      // forwarding build, -1 = don't care
    int         rs_e;
    int         rt_m;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;

    // lw $8 in E, beq reads rs in D
    v = '{default: 0}; v.res_e = 2'b10; v.a3_e = 5'd8; v.a1_d = 5'd8; v.t_rs0 = 1;
    v.stall_f = 1; v.stall_n = 1; v.rs_d = -1; add(v);
    // lw $8 in M
    v = '{default: 0}; v.res_m = 2'b10; v.a3_m = 5'd8; v.a1_d = 5'd8; v.t_rs0 = 1;
    v.stall_f = 1; v.stall_n = 1; v.rs_d = -1; add(v);
    // lw $8 in W
    v = '{default: 0}; v.res_w = 2'b10; v.a3_w = 5'd8; v.a1_d = 5'd8; v.t_rs0 = 1;
    v.rs_d = 4; add(v);
    // addu $9 in M, E reads $9
    v = '{default: 0}; v.res_m = 2'b01; v.a3_m = 5'd9; v.a1_e = 5'd9; v.rs_e = 1; add(v);
    // same register also in W: M still wins
    v = '{default: 0}; v.res_m = 2'b01; v.a3_m = 5'd9; v.a1_e = 5'd9;
    v.res_w = 2'b01; v.a3_w = 5'd9; v.rs_e = 1; add(v);
    // jal in E, jr $31 in D
    v = '{default: 0}; v.res_e = 2'b11; v.a3_e = 5'd31; v.a1_d = 5'd31; v.t_rs0 = 1;
    v.stall_n = 1; v.rs_d = 1; add(v);
    // sw in M, lw $5 in W
    v = '{default: 0}; v.a2_m = 5'd5; v.res_w = 2'b10; v.a3_w = 5'd5; v.rt_m = 1; add(v);
    // register 0 never forwards
    v = '{default: 0}; v.a2_m = 5'd0; v.res_w = 2'b10; v.a3_w = 5'd0; add(v);
    // register 0 never stalls
    v = '{default: 0}; v.res_e = 2'b10; v.a3_e = 5'd0; v.a1_d = 5'd0; v.t_rs0 = 1; add(v);
    // addu $3 in E, ori reads $3 at Tuse=1
    v = '{default: 0}; v.res_e = 2'b01; v.a3_e = 5'd3; v.a1_d = 5'd3; v.t_rs1 = 1;
    v.stall_n = 1; v.rs_d = -1; add(v);
    // alu in E, rt at Tuse=0
    v = '{default: 0}; v.res_e = 2'b01; v.a3_e = 5'd4; v.a2_d = 5'd4; v.t_rt0 = 1;
    v.stall_f = 1; v.stall_n = 1; add(v);
    // lw in M, rt at Tuse=1 (Tnew 1 not greater)
    v = '{default: 0}; v.res_m = 2'b10; v.a3_m = 5'd6; v.a2_d = 5'd6; v.t_rt1 = 1;
    v.stall_n = 1; add(v);
    // E pc and M alu both write $7: E nearest
    v = '{default: 0}; v.res_e = 2'b11; v.a3_e = 5'd7; v.res_m = 2'b01; v.a3_m = 5'd7;
    v.a1_d = 5'd7; v.t_rs0 = 1; v.stall_n = 1; v.rs_d = 1; add(v);
    // W forward into E
    v = '{default: 0}; v.a1_e = 5'd12; v.res_w = 2'b01; v.a3_w = 5'd12; v.rs_e = 3; add(v);
    // M pc forward into E
    v = '{default: 0}; v.a1_e = 5'd13; v.res_m = 2'b11; v.a3_m = 5'd13; v.rs_e = 2; add(v);
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    #4;
    chk("reset_md_busy", int'(md_busy), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd", int'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 0);
    advance();

    // directed vector table (MD idle)
    foreach (vecs[i]) begin
      clear_inputs();
      {tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2} =
        {vecs[i].t_rs0, vecs[i].t_rs1, vecs[i].t_rt0, vecs[i].t_rt1, vecs[i].t_rt2};
      a1_d = vecs[i].a1_d; a2_d = vecs[i].a2_d; a1_e = vecs[i].a1_e;
      a3_e = vecs[i].a3_e; a2_m = vecs[i].a2_m; a3_m = vecs[i].a3_m; a3_w = vecs[i].a3_w;
      res_e = vecs[i].res_e; res_m = vecs[i].res_m; res_w = vecs[i].res_w;
      #4;
      chk($sformatf("vec%0d_stall", i), int'(stall), FWD ? vecs[i].stall_f : vecs[i].stall_n);
      if (!FWD || vecs[i].rs_d >= 0)
        chk($sformatf("vec%0d_fwd_rs_d", i), int'(fwd_rs_d), FWD ? vecs[i].rs_d : 0);
      chk($sformatf("vec%0d_fwd_rs_e", i), int'(fwd_rs_e), FWD ? vecs[i].rs_e : 0);
      chk($sformatf("vec%0d_fwd_rt_m", i), int'(fwd_rt_m), FWD ? vecs[i].rt_m : 0);
      chk($sformatf("vec%0d_md_busy", i), int'(md_busy), 0);
      advance();
    end

    // div then mflo: stalled 11 cycles, free on the 12th
    clear_inputs();
    md_use_d = 1'b1;
    for (int i = 0; i < 12; i++) begin
      md_start_e = (i == 0);
      md_div_e   = 1'b1;
      #4;
      chk($sformatf("div_stall_%0d", i), int'(stall), (i < 11) ? 1 : 0);
      advance();
    end

    // mult then mflo: stalled 6 cycles
    for (int i = 0; i < 7; i++) begin
      md_start_e = (i == 0);
      md_div_e   = 1'b0;
      #4;
      chk($sformatf("mult_stall_%0d", i), int'(stall), (i < 6) ? 1 : 0);
      advance();
    end

    // mult restarted as div two cycles later: reload, no accumulation
    md_start_e = 1'b1; md_div_e = 1'b0;
    #4; advance();
    md_start_e = 1'b0;
    #4; advance();
    for (int i = 0; i < 12; i++) begin
      md_start_e = (i == 0);
      md_div_e   = 1'b1;
      #4;
      chk($sformatf("restart_busy_%0d", i), int'(md_busy), (i < 11) ? 1 : 0);
      advance();
    end

    // div, then reset after 3 cycles clears the counter
    md_start_e = 1'b1; md_div_e = 1'b1;
    #4; advance();
    md_start_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("pre_reset_busy", int'(md_busy), 1);
      advance();
    end
    reset = 1'b1;
    #4;
    chk("in_reset_busy", int'(md_busy), 1);
    advance();
    reset = 1'b0;
    #4;
    chk("post_reset_busy", int'(md_busy), 0);
    chk("post_reset_stall", int'(stall), 0);
    advance();

    // start together with reset: counter held at 0
    reset = 1'b1; md_start_e = 1'b1; md_div_e = 1'b1;
    #4; advance();
    reset = 1'b0; md_start_e = 1'b0;
    #4;
    chk("start_in_reset_busy", int'(md_busy), 0);
    advance();

    // randomized stimulus against the behavioural model
    for (int i = 0; i < 600; i++) begin
      tuse_rs0 = 1'($urandom_range(0, 1)); tuse_rs1 = 1'($urandom_range(0, 1));
      tuse_rt0 = 1'($urandom_range(0, 1)); tuse_rt1 = 1'($urandom_range(0, 1));
      tuse_rt2 = 1'($urandom_range(0, 1));
      a1_d = 5'($urandom_range(0, 3)); a2_d = 5'($urandom_range(0, 3));
      a1_e = 5'($urandom_range(0, 3)); a2_e = 5'($urandom_range(0, 3));
      a3_e = 5'($urandom_range(0, 3)); a2_m = 5'($urandom_range(0, 3));
      a3_m = 5'($urandom_range(0, 3)); a3_w = 5'($urandom_range(0, 3));
      res_e = 2'($urandom_range(0, 3)); res_m = 2'($urandom_range(0, 3));
      res_w = 2'($urandom_range(0, 3));
      md_use_d   = 1'($urandom_range(0, 1));
      md_start_e = ($urandom_range(0, 9) == 0);
      md_div_e   = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 59) == 0);
      #4;
      model_check();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
